// File: rtl/fetch_stage.sv
// Instruction fetch stage: REQ/WAIT/HOLD request FSM, one outstanding memory request, one-entry hold buffer.
// Optional misaligned-redirect trap enabled by defining FETCH_MISALIGN_TRAP_EN (adds MisalignErr).
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        PCSrc,
  input  logic [31:0] PCTarget,
  input  logic        Stall,
  output logic        IReqValid,
  output logic [31:0] IAddr,
  input  logic        IReady,
  input  logic        IRspValid,
  input  logic [31:0] IRspData,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic        MisalignErr
`endif
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t      state_r, state_s;
  logic [31:0] pcf_r, pcf_s, pcf_plus4_s, target_s;
  logic        kill_r, kill_s;
  logic [31:0] buf_instr_r, buf_instr_s, buf_pc_r, buf_pc_s;
  logic [31:0] instrd_r, instrd_s, pcd_r, pcd_s, pcplus4d_r, pcplus4d_s;
  logic        validd_r, validd_s;
  logic        bad_target_s, halted_s, load_s, buffer_s, unbuf_s, ireqvalid_s;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic misalign_r;

  assign bad_target_s = PCSrc && (PCTarget[1:0] != 2'b00);
  assign halted_s     = misalign_r;
  assign target_s     = PCTarget;
  assign MisalignErr  = misalign_r;

  // Sticky misaligned-redirect flag, cleared only by reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      misalign_r <= 1'b0;
    end else begin
      misalign_r <= misalign_r | bad_target_s;
    end
  end
`else
  assign bad_target_s = 1'b0;
  assign halted_s     = 1'b0;
  assign target_s     = PCTarget & 32'hFFFF_FFFC;
`endif

  assign pcf_plus4_s = pcf_r + 32'd4;
  assign load_s   = (state_r == S_WAIT) && IRspValid && !PCSrc && !kill_r && !Stall;
  assign buffer_s = (state_r == S_WAIT) && IRspValid && !PCSrc && !kill_r && Stall;
  assign unbuf_s  = (state_r == S_HOLD) && !PCSrc && !Stall;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= S_REQ;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state and kill-flag logic; a redirect always wins over stall and responses
  always_comb begin
    state_s = state_r;
    kill_s  = kill_r;
    case (state_r)
      S_REQ: begin
        kill_s = PCSrc && IReady && !halted_s && !bad_target_s;
        if (halted_s || bad_target_s) begin
          state_s = S_REQ;
        end else if (IReady) begin
          state_s = S_WAIT;
        end else begin
          state_s = S_REQ;
        end
      end
      S_WAIT: begin
        if (PCSrc && !IRspValid && !bad_target_s) begin
          kill_s = 1'b1;
        end else if (IRspValid || bad_target_s) begin
          kill_s = 1'b0;
        end else begin
          kill_s = kill_r;
        end
        if (bad_target_s) begin
          state_s = S_REQ;
        end else if (!IRspValid) begin
          state_s = S_WAIT;
        end else if (buffer_s) begin
          state_s = S_HOLD;
        end else begin
          state_s = S_REQ;
        end
      end
      S_HOLD: begin
        kill_s = 1'b0;
        if (PCSrc || !Stall) begin
          state_s = S_REQ;
        end else begin
          state_s = S_HOLD;
        end
      end
      default: begin
        state_s = S_REQ;
        kill_s  = 1'b0;
      end
    endcase
  end

  // FSM outputs
  always_comb begin
    ireqvalid_s = 1'b0;
    case (state_r)
      S_REQ:   ireqvalid_s = !halted_s;
      S_WAIT:  ireqvalid_s = 1'b0;
      S_HOLD:  ireqvalid_s = 1'b0;
      default: ireqvalid_s = 1'b0;
    endcase
  end

  // PC, hold buffer and decode-slot next values; an unstalled slot with nothing new becomes a bubble
  always_comb begin
    pcf_s       = pcf_r;
    buf_instr_s = buf_instr_r;
    buf_pc_s    = buf_pc_r;
    instrd_s    = instrd_r;
    pcd_s       = pcd_r;
    pcplus4d_s  = pcplus4d_r;
    validd_s    = validd_r;

    if (PCSrc) begin
      pcf_s = target_s;
    end else if (load_s || buffer_s) begin
      pcf_s = pcf_plus4_s;
    end else begin
      pcf_s = pcf_r;
    end

    if (buffer_s) begin
      buf_instr_s = IRspData;
      buf_pc_s    = pcf_r;
    end else if (PCSrc || unbuf_s) begin
      buf_instr_s = NOP_INSTR;
      buf_pc_s    = 32'h0000_0000;
    end else begin
      buf_instr_s = buf_instr_r;
      buf_pc_s    = buf_pc_r;
    end

    if (PCSrc) begin
      instrd_s = NOP_INSTR;
      validd_s = 1'b0;
    end else if (Stall) begin
      instrd_s = instrd_r;
      validd_s = validd_r;
    end else if (load_s) begin
      instrd_s   = IRspData;
      pcd_s      = pcf_r;
      pcplus4d_s = pcf_plus4_s;
      validd_s   = 1'b1;
    end else if (unbuf_s) begin
      instrd_s   = buf_instr_r;
      pcd_s      = buf_pc_r;
      pcplus4d_s = buf_pc_r + 32'd4;
      validd_s   = 1'b1;
    end else begin
      instrd_s = NOP_INSTR;
      validd_s = 1'b0;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pcf_r       <= RESET_PC;
      kill_r      <= 1'b0;
      buf_instr_r <= NOP_INSTR;
      buf_pc_r    <= 32'h0000_0000;
      instrd_r    <= NOP_INSTR;
      pcd_r       <= 32'h0000_0000;
      pcplus4d_r  <= 32'h0000_0000;
      validd_r    <= 1'b0;
    end else begin
      pcf_r       <= pcf_s;
      kill_r      <= kill_s;
      buf_instr_r <= buf_instr_s;
      buf_pc_r    <= buf_pc_s;
      instrd_r    <= instrd_s;
      pcd_r       <= pcd_s;
      pcplus4d_r  <= pcplus4d_s;
      validd_r    <= validd_s;
    end
  end

  assign IReqValid = ireqvalid_s;
  assign IAddr     = pcf_r;
  assign InstrD    = instrd_r;
  assign PCD       = pcd_r;
  assign PCPlus4D  = pcplus4d_r;
  assign ValidD    = validd_r;

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the PC loaded on reset.
REQ-002 Parameter NOP_INSTR, default 32'h0000_0013 (addi x0,x0,0), SHALL be the instruction presented when the decode slot is empty.
REQ-003 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset_n  in  1  reset, asynchronous, active-low.
REQ-005 PCSrc  in  1  redirect request from the controller, one-cycle pulse.
REQ-006 PCTarget  in  32  redirect target address.
REQ-007 Stall  in  1  decode-stage hold request.
REQ-008 IReqValid  out  1  instruction-memory request valid.
REQ-009 IAddr  out  32  request address; equals PCF.
REQ-010 IReady  in  1  memory accepts the request this cycle.
REQ-011 IRspValid  in  1  read data valid, one cycle.
REQ-012 IRspData  in  32  instruction word.
REQ-013 InstrD  out  32  instruction to decode; op = InstrD[6:0], funct3 = [14:12], funct7b5 = [30].
REQ-014 PCD, PCPlus4D  out  32 each  PC of InstrD and PC+4.
REQ-015 ValidD  out  1  InstrD holds a real fetched instruction.

Function
REQ-016 FSM states SHALL be REQ, WAIT and HOLD; at most one memory request SHALL be outstanding.
REQ-017 REQ: IReqValid=1 and IAddr=PCF; IReady=1 -> WAIT; otherwise stay in REQ with the address stable.
REQ-018 WAIT: IRspValid=1 and Stall=0 -> load InstrD/PCD/PCPlus4D, set ValidD=1, PCF<=PCF+4, go to REQ.
REQ-019 WAIT: IRspValid=1 and Stall=1 -> latch data into the one-entry hold buffer, PCF<=PCF+4, go to HOLD; D registers unchanged.
REQ-020 HOLD: IReqValid=0; when Stall=0 -> move buffer to D registers with ValidD=1, go to REQ.
REQ-021 Stall=1 SHALL freeze InstrD, PCD, PCPlus4D and ValidD.
REQ-022 PCSrc=1 SHALL override Stall: PCF<=PCTarget, ValidD<=0, InstrD<=NOP_INSTR; the hold buffer is discarded and HOLD -> REQ.
REQ-023 PCSrc=1 in WAIT SHALL set a kill flag; the pending response is dropped on arrival without updating PCF or D registers, kill clears, and the FSM goes to REQ.
REQ-024 PCSrc=1 in the same cycle as IRspValid SHALL drop that response (redirect wins).
REQ-025 PCSrc=1 in REQ with IReady=1 SHALL treat the accepted request as killed (WAIT with kill set).
REQ-026 Priority SHALL be reset_n > PCSrc > Stall > normal fetch.
REQ-027 PC arithmetic SHALL be 32-bit modulo; 32'hFFFF_FFFC + 4 SHALL wrap to 0.
REQ-028 Back-to-back throughput SHALL be one instruction per two cycles minimum with zero-latency memory (REQ -> WAIT -> REQ).

Reset
REQ-029 On reset_n=0, immediately: PCF=RESET_PC, state=REQ, kill=0, ValidD=0, InstrD=NOP_INSTR, PCD=0, PCPlus4D=0, buffer cleared.
REQ-030 Reset mid-transaction SHALL abandon the outstanding request; a response arriving after reset release while in REQ SHALL be ignored.
REQ-031 The first IReqValid SHALL appear in the first cycle after reset_n rises.

Configuration
REQ-032 Macro FETCH_MISALIGN_TRAP_EN defined: output MisalignErr (1 bit) added; PCSrc with PCTarget[1:0]!=0 SHALL set MisalignErr sticky until reset and leave the FSM in REQ with IReqValid=0.
REQ-033 Macro undefined: no MisalignErr port; PCTarget[1:0] SHALL be forced to 2'b00 on load.

Verification
REQ-034 Reset release, IReady=1, response one cycle later with 32'h0000_0293 -> InstrD=32'h0000_0293, PCD=0, PCPlus4D=4, ValidD=1; next IAddr=4.
REQ-035 Stall=1 during response 32'h0040_0313 -> state HOLD, D unchanged; Stall=0 -> InstrD=32'h0040_0313 next edge.
REQ-036 PCSrc=1, PCTarget=32'h100 while in WAIT -> late response discarded, ValidD=0, next IAddr=32'h100.
REQ-037 PCSrc and IRspValid in the same cycle with Stall=1 -> response dropped, InstrD=NOP_INSTR, IAddr=PCTarget.
REQ-038 PCF=32'hFFFF_FFFC fetch completes -> next IAddr=0.
REQ-039 With FETCH_MISALIGN_TRAP_EN, PCTarget=32'h102 -> MisalignErr=1, IReqValid=0 until reset.
